// File: rtl/dmux8way16_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmux8way16_stream_pkg
// Description : Shared constants and helpers for the 8-way 16-bit stream
//               demultiplexer and its per-channel FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
package dmux8way16_stream_pkg;

    // Number of output channels and width of the channel selector
    localparam int NUM_CH        = 8;
    localparam int SEL_W         = 3;

    // Default word width and per-channel buffering depth
    localparam int WIDTH_DEFAULT = 16;
    localparam int DEPTH_DEFAULT = 2;

    // One-hot decode of a channel selector
    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] onehot;
        onehot      = '0;
        onehot[sel] = 1'b1;
        return onehot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmux8way16_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dmux_chan_fifo
// Description : Single-channel synchronous FIFO with a registered head word.
//               The head register holds its last value while the FIFO is
//               empty and is cleared to zero by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmux_chan_fifo
    import dmux8way16_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_head;

    logic               w_full;
    logic               w_empty;
    logic               w_do_push;
    logic               w_do_pop;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;
    logic [c_CNT_W-1:0] w_count_kept;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [WIDTH-1:0]   w_head_nxt;

    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_empty   = (r_count == '0);

    // A push into a full FIFO is ignored (no pass-through), as is a pop
    // from an empty one.
    assign w_do_push = push && !w_full;
    assign w_do_pop  = pop && !w_empty;

    // Next read pointer, occupancy and head word.  w_count_kept is the number
    // of older words still stored after the pop; if any remain, the oldest
    // one becomes the head, otherwise an incoming word becomes the head, and
    // with neither the head holds its previous value.
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_kept = r_count;
        w_head_nxt   = r_head;
        if (w_do_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + 1'b1;
            w_count_kept = r_count - 1'b1;
        end
        w_count_nxt = w_count_kept + c_CNT_W'(w_do_push);
        if (w_count_kept != '0) begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end else if (w_do_push) begin
            w_head_nxt = push_data;
        end
    end

    // Pointers, occupancy and head register; pointers wrap modulo DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_head   <= w_head_nxt;
        end
    end

    // Storage array; contents are only meaningful under the occupancy count
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign full      = w_full;
    assign empty     = w_empty;
    assign head_data = r_head;

endmodule
`default_nettype wire

// File: rtl/dmux8way16_stream.sv
`default_nettype none
// ============================================================================
// Module      : dmux8way16_stream
// Description : Sequential 8-way demultiplexer for WIDTH-bit words.  Each
//               accepted word is routed by in_sel into one of eight buffered
//               channels, each with its own valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module dmux8way16_stream
    import dmux8way16_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic                    busy
);

    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_sel_hot;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop;
    logic              w_accept;

    // Readiness depends only on the selected channel's registered fill state,
    // never on out_ready, so a full channel cannot forward a word straight
    // through even when it is being drained in the same cycle.
    assign in_ready  = rst_n && !w_full[in_sel];
    assign w_accept  = in_valid && in_ready;
    assign w_sel_hot = sel_onehot(in_sel);
    assign w_push    = {NUM_CH{w_accept}} & w_sel_hot;

    // Every channel with a word and a ready consumer pops independently
    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    assign busy      = |out_valid;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
            dmux_chan_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (w_push[k]),
                .push_data (in_data),
                .pop       (w_pop[k]),
                .full      (w_full[k]),
                .empty     (w_empty[k]),
                .head_data (out_data[k*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule
`default_nettype wire
